georgios_core: RTL and testbench

//  Execution core of the Georgios CPU. Contains the instruction decoder, a
//  16-entry register file and a 1-op-bit add/sub ALU.
//  The program sequencer feeds it one 4-byte instruction per cycle:

---
 rtl/georgios_core_if.sv | 33 +++
 rtl/georgios_core.sv | 152 +++++++++++++++
 tb/tb_georgios_core.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/georgios_core_if.sv
// Bus between the Georgios program sequencer (master) and the execution core (slave).
// Carries the instruction word, decoded/execution status and the debug register port.
interface georgios_core_if #(
  parameter int w       = 8,
  parameter int op_w    = 8,
  parameter int sel_w   = 4,
  parameter int flags_w = 6
);
  logic               instr_valid;
  logic [op_w-1:0]    i0;
  logic [w-1:0]       i1;
  logic [w-1:0]       i2;
  logic [w-1:0]       i3;
  logic [flags_w-1:0] flags;
  logic [w-1:0]       result;
  logic               status;
  logic               wr_en;
  logic [sel_w-1:0]   wr_sel;
  logic               halted;
  logic               illegal;
  logic [sel_w-1:0]   dbg_sel;
  logic [w-1:0]       dbg_data;

  modport master (
    output instr_valid, i0, i1, i2, i3, dbg_sel,
    input  flags, result, status, wr_en, wr_sel, halted, illegal, dbg_data
  );

  modport slave (
    input  instr_valid, i0, i1, i2, i3, dbg_sel,
    output flags, result, status, wr_en, wr_sel, halted, illegal, dbg_data
  );
endinterface

// File: rtl/georgios_core.sv
// Georgios CPU execution core: decoder, 16-entry register file and add/sub ALU.
// Stage 1 captures and decodes the instruction, stage 2 executes and writes back.
module georgios_core #(
  parameter int w       = 8,
  parameter int op_w    = 8,
  parameter int sel_w   = 4,
  parameter int flags_w = 6
) (
  input  logic            clock,
  input  logic            reset,
  georgios_core_if.slave  bus
);

  localparam int F_HALT  = 0;
  localparam int F_ALUOP = 1;
  localparam int F_ZENB  = 2;
  localparam int F_YENB  = 3;
  localparam int F_XENB  = 4;
  localparam int F_AIMM  = 5;

  localparam logic [op_w-1:0] OP_NOP  = op_w'(8'h00);
  localparam logic [op_w-1:0] OP_SET  = op_w'(8'h01);
  localparam logic [op_w-1:0] OP_MOV  = op_w'(8'h02);
  localparam logic [op_w-1:0] OP_ADD  = op_w'(8'h03);
  localparam logic [op_w-1:0] OP_SUB  = op_w'(8'h04);
  localparam logic [op_w-1:0] OP_ADDI = op_w'(8'h05);
  localparam logic [op_w-1:0] OP_HALT = op_w'(8'hFF);

  logic [w-1:0]       r_regs [2**sel_w];
  logic [sel_w-1:0]   r_xSel;
  logic [sel_w-1:0]   r_ySel;
  logic [sel_w-1:0]   r_zSel;
  logic [w-1:0]       r_imm;
  logic [flags_w-1:0] r_flags;
  logic               r_illegal;
  logic [w-1:0]       r_result;
  logic               r_status;
  logic               r_wrEn;
  logic [sel_w-1:0]   r_wrSel;
  logic               r_halted;

  logic [flags_w-1:0] w_decFlags;
  logic               w_decIllegal;
  logic [sel_w-1:0]   w_decZSel;
  logic               w_capture;
  logic [w-1:0]       w_x;
  logic [w-1:0]       w_y;
  logic [w:0]         w_alu;
  logic               w_unusedArgBits;

  assign w_unusedArgBits = ^{bus.i1[w-1:sel_w], bus.i3[w-1:sel_w]};

  // SET/MOV are expressed as 0+imm and 0+regs[i2] so every write goes through the ALU.
  always_comb begin
    w_decFlags   = '0;
    w_decIllegal = 1'b0;
    w_decZSel    = bus.i3[sel_w-1:0];
    case (bus.i0)
      OP_NOP: ;
      OP_SET: begin
        w_decFlags[F_AIMM] = 1'b1;
        w_decFlags[F_ZENB] = 1'b1;
        w_decZSel          = bus.i1[sel_w-1:0];
      end
      OP_MOV: begin
        w_decFlags[F_YENB] = 1'b1;
        w_decFlags[F_ZENB] = 1'b1;
        w_decZSel          = bus.i1[sel_w-1:0];
      end
      OP_ADD: begin
        w_decFlags[F_XENB] = 1'b1;
        w_decFlags[F_YENB] = 1'b1;
        w_decFlags[F_ZENB] = 1'b1;
      end
      OP_SUB: begin
        w_decFlags[F_XENB]  = 1'b1;
        w_decFlags[F_YENB]  = 1'b1;
        w_decFlags[F_ZENB]  = 1'b1;
        w_decFlags[F_ALUOP] = 1'b1;
      end
      OP_ADDI: begin
        w_decFlags[F_AIMM] = 1'b1;
        w_decFlags[F_XENB] = 1'b1;
        w_decFlags[F_ZENB] = 1'b1;
      end
      OP_HALT: w_decFlags[F_HALT] = 1'b1;
      default: w_decIllegal = 1'b1;
    endcase
  end

  // A HALT still sitting in IR blocks the next capture too, since halted only rises one edge later.
  assign w_capture = bus.instr_valid && !r_halted && !r_flags[F_HALT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_xSel    <= '0;
      r_ySel    <= '0;
      r_zSel    <= '0;
      r_imm     <= '0;
      r_flags   <= '0;
      r_illegal <= 1'b0;
    end else if (w_capture) begin
      r_xSel    <= bus.i1[sel_w-1:0];
      r_ySel    <= bus.i2[sel_w-1:0];
      r_zSel    <= w_decZSel;
      r_imm     <= bus.i2;
      r_flags   <= w_decFlags;
      r_illegal <= w_decIllegal;
    end else begin
      r_xSel  <= '0;
      r_ySel  <= '0;
      r_zSel  <= '0;
      r_imm   <= '0;
      r_flags <= '0;
    end
  end

  assign w_x   = r_flags[F_XENB] ? r_regs[r_xSel] : '0;
  assign w_y   = r_flags[F_AIMM] ? r_imm : (r_flags[F_YENB] ? r_regs[r_ySel] : '0);
  // Bit w is carry for ADD and, because the subtraction is unsigned over w+1 bits, borrow for SUB.
  assign w_alu = r_flags[F_ALUOP] ? ({1'b0, w_x} - {1'b0, w_y}) : ({1'b0, w_x} + {1'b0, w_y});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2**sel_w; k++) r_regs[k] <= '0;
      r_result <= '0;
      r_status <= 1'b0;
      r_wrEn   <= 1'b0;
      r_wrSel  <= '0;
      r_halted <= 1'b0;
    end else begin
      r_wrEn <= r_flags[F_ZENB];
      if (r_flags[F_ZENB]) begin
        r_regs[r_zSel] <= w_alu[w-1:0];
        r_result       <= w_alu[w-1:0];
        r_wrSel        <= r_zSel;
      end
      if (r_flags[F_XENB]) r_status <= w_alu[w];
      if (r_flags[F_HALT]) r_halted <= 1'b1;
    end
  end

  assign bus.flags    = r_flags;
  assign bus.result   = r_result;
  assign bus.status   = r_status;
  assign bus.wr_en    = r_wrEn;
  assign bus.wr_sel   = r_wrSel;
  assign bus.halted   = r_halted;
  assign bus.illegal  = r_illegal;
  assign bus.dbg_data = r_regs[bus.dbg_sel];

endmodule

// File: tb/tb_georgios_core.sv
// Scoreboard bench for georgios_core: a small ISA model queues every expected write,
// and a negedge monitor pops and compares them when the core asserts wr_en.
module tb_georgios_core;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] data;
    logic       st;
    int         cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cycle = 0;
  int   testsRun = 0;
  int   testsFailed = 0;

  exp_t       expQ[$];
  logic [7:0] mRegs [16];
  logic       mStatus;
  logic       mHalted;

  georgios_core_if bus ();

  georgios_core dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard comparator: every write the core performs must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.wr_en === 1'b1) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_write: wr_sel=%0d result=%h, required no write", bus.wr_sel, bus.result);
      end else begin
        e = expQ.pop_front();
        testsRun++;
        if (bus.wr_sel !== e.sel) begin
          testsFailed++;
          $display("[TB] FAIL wr_sel: got %0d, expected %0d", bus.wr_sel, e.sel);
        end
        testsRun++;
        if (bus.result !== e.data) begin
          testsFailed++;
          $display("[TB] FAIL result: got %h, expected %h (r%0d)", bus.result, e.data, e.sel);
        end
        testsRun++;
        if (bus.status !== e.st) begin
          testsFailed++;
          $display("[TB] FAIL status: got %b, expected %b (r%0d)", bus.status, e.st, e.sel);
        end
        testsRun++;
        if (cycle !== e.cyc) begin
          testsFailed++;
          $display("[TB] FAIL latency: write seen in cycle %0d, expected cycle %0d (r%0d)", cycle, e.cyc, e.sel);
        end
      end
    end
  end

  task automatic modelReset();
    for (int k = 0; k < 16; k++) mRegs[k] = 8'h00;
    mStatus = 1'b0;
    mHalted = 1'b0;
    expQ.delete();
  endtask

  // Drives one instruction for one cycle and queues the write the ISA says it produces.
  task automatic applyStimulus(input logic [7:0] op, input logic [7:0] a1,
                               input logic [7:0] a2, input logic [7:0] a3);
    exp_t       e;
    logic [8:0] t;
    logic [7:0] x;
    logic [7:0] y;
    bus.instr_valid = 1'b1;
    bus.i0 = op;
    bus.i1 = a1;
    bus.i2 = a2;
    bus.i3 = a3;
    x = mRegs[a1[3:0]];
    y = mRegs[a2[3:0]];
    e.cyc = cycle + 2;
    if (!mHalted) begin
      case (op)
        8'h01: begin e.sel = a1[3:0]; e.data = a2; end
        8'h02: begin e.sel = a1[3:0]; e.data = y; end
        8'h03: begin t = {1'b0, x} + {1'b0, y}; e.sel = a3[3:0]; e.data = t[7:0]; mStatus = t[8]; end
        8'h04: begin e.sel = a3[3:0]; e.data = x - y; mStatus = (x < y); end
        8'h05: begin t = {1'b0, x} + {1'b0, a2}; e.sel = a3[3:0]; e.data = t[7:0]; mStatus = t[8]; end
        8'hFF: mHalted = 1'b1;
        default: ;
      endcase
      if (op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h05}) begin
        e.st = mStatus;
        mRegs[e.sel] = e.data;
        expQ.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    bus.instr_valid = 1'b0;
    bus.i0 = 8'h00;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    bus.instr_valid = 1'b0;
    bus.i0 = 8'h00;
    for (int k = 0; k < 20 && expQ.size() != 0; k++) begin
      @(posedge clock);
      #1;
    end
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain_timeout: %0d writes outstanding, expected 0", expQ.size());
    end
    idle(2);
  endtask

  task automatic test_reset();
    bus.instr_valid = 1'b0;
    bus.i0 = 8'h00;
    bus.i1 = 8'h00;
    bus.i2 = 8'h00;
    bus.i3 = 8'h00;
    bus.dbg_sel = 4'd0;
    reset = 1'b1;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    testsRun++;
    if ({bus.flags, bus.result, bus.status, bus.wr_en, bus.wr_sel, bus.halted, bus.illegal} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: flags=%b result=%h status=%b wr_en=%b wr_sel=%0d halted=%b illegal=%b, expected all 0",
               bus.flags, bus.result, bus.status, bus.wr_en, bus.wr_sel, bus.halted, bus.illegal);
    end
    for (int k = 0; k < 16; k++) begin
      bus.dbg_sel = 4'(k);
      #1;
      testsRun++;
      if (bus.dbg_data !== 8'h00) begin
        testsFailed++;
        $display("[TB] FAIL reset_reg: r%0d=%h, expected 00", k, bus.dbg_data);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_add();
    applyStimulus(8'h01, 8'd1, 8'd5, 8'd0);
    applyStimulus(8'h01, 8'd2, 8'd3, 8'd0);
    applyStimulus(8'h03, 8'd1, 8'd2, 8'd3);
    testsRun++;
    if (bus.flags !== 6'b011100) begin
      testsFailed++;
      $display("[TB] FAIL add_flags: got %b, expected 011100", bus.flags);
    end
    drain();
    bus.dbg_sel = 4'd3;
    #1;
    testsRun++;
    if (bus.dbg_data !== 8'd8) begin
      testsFailed++;
      $display("[TB] FAIL add_r3: got %h, expected 08", bus.dbg_data);
    end
  endtask

  task automatic test_addi_carry();
    applyStimulus(8'h01, 8'd4, 8'hFF, 8'd0);
    applyStimulus(8'h05, 8'd4, 8'd1, 8'd5);
    drain();
    bus.dbg_sel = 4'd5;
    #1;
    testsRun++;
    if (bus.dbg_data !== 8'h00 || bus.status !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL addi_wrap: r5=%h status=%b, expected 00 and 1", bus.dbg_data, bus.status);
    end
  endtask

  task automatic test_sub_borrow();
    applyStimulus(8'h04, 8'd2, 8'd1, 8'd6);
    applyStimulus(8'h04, 8'd1, 8'd2, 8'd7);
    drain();
    bus.dbg_sel = 4'd6;
    #1;
    testsRun++;
    if (bus.dbg_data !== 8'hFE) begin
      testsFailed++;
      $display("[TB] FAIL sub_r6: got %h, expected FE", bus.dbg_data);
    end
    bus.dbg_sel = 4'd7;
    #1;
    testsRun++;
    if (bus.dbg_data !== 8'h02 || bus.status !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL sub_r7: r7=%h status=%b, expected 02 and 0", bus.dbg_data, bus.status);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(8'h02, 8'd8, 8'd3, 8'd0);
    applyStimulus(8'h03, 8'd8, 8'd8, 8'd8);
    drain();
    bus.dbg_sel = 4'd8;
    #1;
    testsRun++;
    if (bus.dbg_data !== 8'd16) begin
      testsFailed++;
      $display("[TB] FAIL hazard_r8: got %h, expected 10", bus.dbg_data);
    end
  endtask

  task automatic test_reset_midflight();
    applyStimulus(8'h01, 8'd11, 8'h5A, 8'd0);
    applyStimulus(8'h01, 8'd10, 8'h77, 8'd0);
    reset = 1'b1;
    #1;
    testsRun++;
    if (bus.wr_en !== 1'b0 || bus.result !== 8'h00 || bus.flags !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL midflight_outputs: wr_en=%b result=%h flags=%b, expected 0", bus.wr_en, bus.result, bus.flags);
    end
    bus.dbg_sel = 4'd11;
    #1;
    testsRun++;
    if (bus.dbg_data !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL midflight_r11: got %h, expected 00", bus.dbg_data);
    end
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    idle(3);
    bus.dbg_sel = 4'd10;
    #1;
    testsRun++;
    if (bus.dbg_data !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL midflight_r10: got %h, expected 00 (write aborted)", bus.dbg_data);
    end
  endtask

  task automatic test_illegal_halt();
    applyStimulus(8'h01, 8'd8, 8'd16, 8'd0);
    drain();
    applyStimulus(8'h42, 8'd1, 8'd2, 8'd3);
    testsRun++;
    if (bus.illegal !== 1'b1 || bus.flags !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL illegal_flag: illegal=%b flags=%b, expected 1 and 000000", bus.illegal, bus.flags);
    end
    idle(3);
    testsRun++;
    if (bus.illegal !== 1'b1 || bus.result !== 8'd16) begin
      testsFailed++;
      $display("[TB] FAIL illegal_hold: illegal=%b result=%h, expected 1 and 10", bus.illegal, bus.result);
    end
    applyStimulus(8'hFF, 8'd0, 8'd0, 8'd0);
    testsRun++;
    if (bus.flags !== 6'b000001 || bus.illegal !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL halt_decode: flags=%b illegal=%b, expected 000001 and 0", bus.flags, bus.illegal);
    end
    applyStimulus(8'h01, 8'd9, 8'd1, 8'd0);
    testsRun++;
    if (bus.halted !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL halted_set: got %b, expected 1", bus.halted);
    end
    applyStimulus(8'h01, 8'd9, 8'd1, 8'd0);
    drain();
    bus.dbg_sel = 4'd9;
    #1;
    testsRun++;
    if (bus.dbg_data !== 8'h00 || bus.halted !== 1'b1 || bus.flags !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL halted_ignore: r9=%h halted=%b flags=%b, expected 00, 1, 000000", bus.dbg_data, bus.halted, bus.flags);
    end
  endtask

  task automatic test_halt_cleared_by_reset();
    reset = 1'b1;
    #1;
    testsRun++;
    if (bus.halted !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL halt_reset: halted=%b, expected 0", bus.halted);
    end
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    applyStimulus(8'h01, 8'd9, 8'd1, 8'd0);
    drain();
    bus.dbg_sel = 4'd9;
    #1;
    testsRun++;
    if (bus.dbg_data !== 8'h01) begin
      testsFailed++;
      $display("[TB] FAIL post_halt_set: r9=%h, expected 01", bus.dbg_data);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi_carry();
    test_sub_borrow();
    test_back_to_back();
    test_reset_midflight();
    test_illegal_halt();
    test_halt_cleared_by_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
